// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//
// Immediate-generation stage between fetch and decode. Each accepted
// instruction is classified by opcode/funct3, its immediate is extended to
// XLEN, and the PC-relative target (B, J, AUIPC) is precomputed. Results sit
// in a DEPTH-entry valid/ready FIFO so fetch and decode stall independently.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   DEPTH  FIFO entries, power of two, 2..8
//
// Ports:
//   clk, rst_n (synchronous, active-low), flush (synchronous)
//   in_valid/in_ready/in_instr/in_pc       upstream handshake and payload
//   out_valid/out_ready                    downstream handshake
//   out_instr/out_pc/out_imm/out_fmt/out_target/out_illegal  head entry
//   count                                  current occupancy
//
// Build option:
//   IMM_GEN_ZIMM_EN  when defined, SYSTEM opcode with funct3 101/110/111 is
//                    decoded as format Z (zero-extended CSR uimm). Otherwise
//                    every SYSTEM instruction is format I.

module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [XLEN-1:0]           in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_imm,
    output logic [2:0]                out_fmt,
    output logic [XLEN-1:0]           out_target,
    output logic                      out_illegal,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_I_SH = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;
`ifdef IMM_GEN_ZIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd7;
`endif

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            dec_has_tgt;
    entry_t          new_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        dec_has_tgt = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // shift amount only; instr[30] selects SRL/SRA, not part of imm
                    dec_fmt = FMT_I_SH;
                    if (XLEN == 64) begin
                        dec_imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
                    end else begin
                        dec_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    end
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt     = FMT_B;
                dec_has_tgt = 1'b1;
                dec_imm     = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                               in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt     = FMT_U;
                dec_has_tgt = (opcode == OP_AUIPC);
                // upper bits beyond the shift are sign copies, so shifting them out is harmless
                dec_imm     = {{(XLEN-20){in_instr[31]}}, in_instr[31:12]} << 12;
            end
            OP_JAL: begin
                dec_fmt     = FMT_J;
                dec_has_tgt = 1'b1;
                dec_imm     = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
                if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_fmt = FMT_Z;
                    dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
                end
`else
                dec_fmt = FMT_I;
                dec_imm = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
`endif
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        new_entry.instr   = in_instr;
        new_entry.pc      = in_pc;
        new_entry.imm     = dec_imm;
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
        new_entry.target  = dec_has_tgt ? (in_pc + dec_imm) : '0;
    end

    // FIFO
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    // in_ready depends only on stored occupancy, never on out_ready
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign out_instr   = mem_q[rd_ptr_q].instr;
    assign out_pc      = mem_q[rd_ptr_q].pc;
    assign out_imm     = mem_q[rd_ptr_q].imm;
    assign out_fmt     = mem_q[rd_ptr_q].fmt;
    assign out_target  = mem_q[rd_ptr_q].target;
    assign out_illegal = mem_q[rd_ptr_q].illegal;
    assign count       = count_q;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the pipelined RV32/RV64 core, placed between instruction fetch and decode. It classifies the instruction format from the opcode and funct3, builds the sign- or zero-extended immediate at XLEN width, and precomputes the PC-relative target for branches, JAL and AUIPC. Results are buffered in a small valid/ready FIFO, so fetch and decode stall independently and the stage can be flushed on redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- DEPTH, 2, FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous and active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  the upstream instruction is valid.
- in_ready  out  1  the stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_instr  out  32  instruction word of the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 I_SH, 3 S, 4 B, 5 U, 6 J, 7 Z.
- out_target  out  XLEN  out_pc + out_imm, valid for B, J and U(AUIPC); 0 otherwise.
- out_illegal  out  1  the opcode is not recognised.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
Format decode is combinational on in_instr and is captured at push:
- opcode 0010011 with funct3 001 or 101: I_SH.
  - XLEN=32: imm = zero-extended instr[24:20].
  - XLEN=64: imm = zero-extended instr[25:20].
  - instr[30] is ignored for the immediate.
- opcodes 0010011 (other funct3), 0000011 and 1100111: I. imm = sext(instr[31:20]).
- opcode 0100011: S. imm = sext({instr[31:25], instr[11:7]}).
- opcode 1100011: B. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- opcodes 0110111 (LUI) and 0010111 (AUIPC): U. imm = sext({instr[31:12], 12'b0}) to XLEN.
  - The target is computed for AUIPC only; LUI target is 0.
- opcode 1101111: J. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- opcode 1110011: I. See Configuration for the Z variant.
- any other opcode: NONE. imm = 0, target = 0, illegal = 1.
- Target arithmetic is modulo 2^XLEN; wrap-around is silent.

FIFO behaviour:
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- When full, a simultaneous pop does not enable a push in the same cycle.
- When empty, no bypass: a pushed entry becomes visible on the next edge.

## Timing
- Latency: an instruction pushed on edge N appears on the outputs from edge N, at the earliest on the cycle following the push.
- Throughput: one instruction per cycle while count < DEPTH.
- Push and pop in the same cycle leave count unchanged.
- flush: at the next edge, count = 0, pointers = 0, out_valid = 0, and any same-cycle push or pop is discarded. Entry storage is not cleared.
- rst_n low at an edge has the same effect as flush.
  - In addition, all storage is zeroed, so out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal and count all read 0.
  - in_ready = 1 after reset.
- Reset asserted mid-stream drops all buffered entries; there is no partial drain.
- out_* data reflects mem[rd_ptr] and is held stable while out_valid=1 and out_ready=0.

## Configuration
- IMM_GEN_ZIMM_EN defined:
  - opcode 1110011 with funct3 in {101, 110, 111} is format Z.
  - imm = zero-extended instr[19:15] (the CSR uimm).
  - Other funct3 values remain I.
- IMM_GEN_ZIMM_EN undefined: all 1110011 instructions are I with imm = sext(instr[31:20]). Code 7 is never produced.

## Test plan
- Reset, then XLEN=32: push 0xFFF00093 at pc 0x100. Required: out_fmt=1, out_imm=0xFFFFFFFF, out_target=0, out_illegal=0.
- Push 0xFE000EE3 (beq -4) at pc 0x200. Required: out_fmt=4, out_imm=0xFFFFFFFC, out_target=0x1FC. Then push 0x008000EF at pc 0x10. Required: fmt=6, imm=8, target=0x18.
- Push 0x4030D093 (srai x1,x1,3). Required: fmt=2, imm=3. Push opcode 0x7F. Required: fmt=0, imm=0, illegal=1.
- XLEN=64: push 0x800000B7 (lui). Required: imm=0xFFFFFFFF80000000, target=0. Push srai with shamt 33. Required: imm=33.
- DEPTH=2, out_ready=0: push three instructions back to back. Required: in_ready=0 after two pushes, count=2, the third is not accepted. Raising out_ready drains both in order at one per cycle.
- With count=2, assert flush together with in_valid=1. Required: next cycle count=0, out_valid=0, in_ready=1. With IMM_GEN_ZIMM_EN, push 0x0007D073 (csrrwi uimm=15). Required: fmt=7, imm=15.
